// File: rtl/spike_mac_seq.sv
// Time-multiplexed spike/weight multiply-accumulate: sums the weights of active spikes
// LANES per cycle into a saturating accumulator, emitting one result per in_last-terminated run.
module spike_mac_seq #(
  parameter int N_IN      = 25,
  parameter int W_WIDTH   = 16,
  parameter int LANES     = 5,
  parameter int ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [N_IN-1:0]             spikes_in,
  input  logic [N_IN*W_WIDTH-1:0]     weights_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] sum_out,
  output logic                        sat_out
);

  localparam int CHUNKS = (N_IN + LANES - 1) / LANES;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SLOTS  = 2 ** CNT_W;
  localparam int PAD_N  = SLOTS * LANES;
  localparam int SUM_W  = W_WIDTH + $clog2(LANES + 1);
  localparam int MAX_W  = (ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W;
  localparam int EXT_W  = MAX_W + 1;

  localparam logic signed [EXT_W-1:0] ACC_MAX =
    {{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    {{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_last;
  logic [N_IN-1:0]               r_spk;
  logic [N_IN*W_WIDTH-1:0]       r_wgt;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic                          r_sat;
  logic                          r_in_ready;
  logic                          r_out_valid;

  logic [PAD_N-1:0]              w_spk_pad;
  logic [PAD_N*W_WIDTH-1:0]      w_wgt_pad;
  logic                          w_spk_ch [SLOTS][LANES];
  logic signed [W_WIDTH-1:0]     w_wgt_ch [SLOTS][LANES];
  logic signed [SUM_W-1:0]       w_lane;
  logic signed [EXT_W-1:0]       w_sum;

  function automatic logic signed [ACC_WIDTH-1:0] sat_clip(input logic signed [EXT_W-1:0] v);
    if (v > ACC_MAX)      sat_clip = ACC_MAX[ACC_WIDTH-1:0];
    else if (v < ACC_MIN) sat_clip = ACC_MIN[ACC_WIDTH-1:0];
    else                  sat_clip = v[ACC_WIDTH-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [EXT_W-1:0] v);
    sat_hit = (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  // Zero padding past N_IN makes the tail of the last chunk contribute nothing
  always_comb begin
    w_spk_pad = PAD_N'(r_spk);
    w_wgt_pad = (PAD_N*W_WIDTH)'(r_wgt);
    for (int c = 0; c < SLOTS; c++) begin
      for (int l = 0; l < LANES; l++) begin
        w_spk_ch[c][l] = w_spk_pad[c*LANES + l];
        w_wgt_ch[c][l] = w_wgt_pad[(c*LANES + l)*W_WIDTH +: W_WIDTH];
      end
    end
  end

  always_comb begin
    w_lane = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_spk_ch[r_cnt][l]) w_lane = w_lane + SUM_W'(w_wgt_ch[r_cnt][l]);
    end
    w_sum = EXT_W'(r_acc) + EXT_W'(w_lane);
  end

  // Operand capture: data only, so no reset
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      r_spk <= spikes_in;
      r_wgt <= weights_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_last     <= in_last;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc <= sat_clip(w_sum);
          if (sat_hit(w_sum)) r_sat <= 1'b1;
          if (r_cnt == CNT_W'(CHUNKS - 1)) begin
            r_cnt <= '0;
            if (r_last) begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum_out   = r_acc;
  assign sat_out   = r_sat;

endmodule

// File: tb/tb_spike_mac_seq.sv
// Directed bench for spike_mac_seq: default instance plus N_IN=23 and ACC_WIDTH=18 instances
// fed from the same stimulus, each checked against hand-computed sums.
module tb_spike_mac_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [24:0]  spikes = '0;
  logic [399:0] weights = '0;

  logic               rdy0, rdy1, rdy2, ov0, ov1, ov2, sat0, sat1, sat2;
  logic signed [23:0] sum0, sum1;
  logic signed [17:0] sum2;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  spike_mac_seq u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
    .spikes_in(spikes), .weights_in(weights), .out_valid(ov0), .out_ready(out_ready),
    .sum_out(sum0), .sat_out(sat0));

  spike_mac_seq #(.N_IN(23)) u_n23 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
    .spikes_in(spikes[22:0]), .weights_in(weights[367:0]), .out_valid(ov1),
    .out_ready(out_ready), .sum_out(sum1), .sat_out(sat1));

  spike_mac_seq #(.ACC_WIDTH(18)) u_a18 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_last(in_last),
    .spikes_in(spikes), .weights_in(weights), .out_valid(ov2), .out_ready(out_ready),
    .sum_out(sum2), .sat_out(sat2));

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [399:0] fillw(input logic [15:0] v);
    logic [399:0] r;
    for (int i = 0; i < 25; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  // Called at posedge+1 with the block idle; returns at posedge+1 after the accept edge
  task automatic send(input logic [24:0] s, input logic [399:0] w, input logic last);
    spikes   = s;
    weights  = w;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    spikes   = ~s;
    weights  = ~w;
    in_last  = ~last;
  endtask

  task automatic wait_evt(output int n);
    n = 0;
    while (!ov0 && !rdy0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_rdy_after"}, rdy0, 1);
    check_eq({tag, "_ov_after"}, ov0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_rdy", rdy0, 1);
    check_eq("rst_ov", ov0, 0);
    check_eq("rst_sum", sum0, 0);
    check_eq("rst_sat", sat0, 0);

    // All ones, unit weights
    send('1, fillw(16'd1), 1'b1);
    wait_evt(lat);
    check_eq("ones_lat", lat, 5);
    check_eq("ones_ov", ov0, 1);
    check_eq("ones_sum", sum0, 25);
    check_eq("ones_sat", sat0, 0);
    check_eq("ones_sum_n23", sum1, 23);
    check_eq("ones_sum_a18", sum2, 25);
    consume("ones");

    // Even spikes, weight -3
    send(25'h1555555, fillw(16'hFFFD), 1'b1);
    wait_evt(lat);
    check_eq("even_lat", lat, 5);
    check_eq("even_sum", sum0, -39);
    check_eq("even_sum_n23", sum1, -36);
    check_eq("even_ov_n23", ov1, 1);
    consume("even");

    // Multi-vector sum: A (no result), B (result), then fresh C
    send(25'h1F, fillw(16'd2), 1'b0);
    wait_evt(lat);
    check_eq("vecA_lat", lat, 5);
    check_eq("vecA_ov", ov0, 0);
    check_eq("vecA_rdy", rdy0, 1);
    send(25'h7, fillw(16'd5), 1'b1);
    wait_evt(lat);
    check_eq("vecB_lat", lat, 5);
    check_eq("vecB_sum", sum0, 25);
    consume("vecB");
    send(25'h1, fillw(16'd7), 1'b1);
    wait_evt(lat);
    check_eq("vecC_sum", sum0, 7);
    consume("vecC");

    // Saturation on the 18-bit instance
    send('1, fillw(16'h7FFF), 1'b1);
    wait_evt(lat);
    check_eq("satp_sum_a18", sum2, 131071);
    check_eq("satp_sat_a18", sat2, 1);
    check_eq("satp_sum", sum0, 819175);
    check_eq("satp_sat", sat0, 0);
    consume("satp");
    check_eq("satp_clr", sat2, 0);
    send('1, fillw(16'h8000), 1'b1);
    wait_evt(lat);
    check_eq("satn_sum_a18", sum2, -131072);
    check_eq("satn_sat_a18", sat2, 1);
    check_eq("satn_sum", sum0, -819200);
    consume("satn");
    check_eq("satn_clr", sat2, 0);
    check_eq("satn_acc_clr", sum2, 0);

    // Back-pressure in DONE with in_valid asserted
    send('1, fillw(16'd1), 1'b1);
    wait_evt(lat);
    check_eq("hold_lat", lat, 5);
    in_valid = 1'b1;
    spikes   = '1;
    weights  = fillw(16'd9);
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("hold_ov", ov0, 1);
      check_eq("hold_sum", sum0, 25);
      check_eq("hold_rdy", rdy0, 0);
    end
    in_valid = 1'b0;
    consume("hold");
    check_eq("hold_sum_clr", sum0, 0);

    // Reset during the third accumulate cycle
    send('1, fillw(16'd5), 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_ov", ov0, 0);
    check_eq("abort_sum", sum0, 0);
    check_eq("abort_rdy", rdy0, 1);
    send('1, fillw(16'd1), 1'b1);
    wait_evt(lat);
    check_eq("after_abort_lat", lat, 5);
    check_eq("after_abort_sum", sum0, 25);
    consume("after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
